// File: rtl/game_sequencer.sv
// Game-state sequencer for the dinosaur game: IDLE/RUN/OVER flow, level-paced step strobe, BCD score and level.
// Optional best-score tracking is built when the HISCORE_EN macro is defined.
module game_sequencer #(
    parameter int DIGITS    = 2,
    parameter int LEVELW    = 3,
    parameter int STEP_BASE = 8,
    parameter int STEP_MIN  = 2,
    parameter int LEVEL_PTS = 10,
    parameter int OVER_HOLD = 16
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  tick,
    input  logic                  jump,
    input  logic                  collide,
    output logic                  start,
    output logic                  running,
    output logic                  pause,
    output logic                  step,
    output logic [4*DIGITS-1:0]   score,
    output logic [LEVELW-1:0]     level,
    output logic [4*DIGITS-1:0]   hiscore,
    output logic                  new_record
);

    localparam int SW = $clog2(STEP_BASE + 1);
    localparam int HW = $clog2(OVER_HOLD + 1);
    localparam int LW = $clog2(LEVEL_PTS + 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       step_cnt_q, step_cnt_d;
    logic [HW-1:0]       hold_q, hold_d;
    logic [LW-1:0]       lvl_cnt_q, lvl_cnt_d;
    logic [4*DIGITS-1:0] score_q, score_d, score_inc;
    logic [LEVELW-1:0]   level_q, level_d;
    logic                jump_s1_q, jump_s2_q, jump_prev_q;
    logic                jump_evt, score_max, carry, step_due;
    logic                hs_upd, rec_clr;
    int                  step_period;

    // jump is active-low; the event is the synchronised falling edge.
    assign jump_evt = jump_prev_q & ~jump_s2_q;

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            jump_s1_q   <= 1'b0;
            jump_s2_q   <= 1'b0;
            jump_prev_q <= 1'b0;
        end else begin
            jump_s1_q   <= jump;
            jump_s2_q   <= jump_s1_q;
            jump_prev_q <= jump_s2_q;
        end
    end

    always_comb begin
        score_inc = score_q;
        carry     = 1'b1;
        score_max = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (score_q[4*i +: 4] != 4'd9) score_max = 1'b0;
            if (carry) begin
                if (score_q[4*i +: 4] == 4'd9) begin
                    score_inc[4*i +: 4] = 4'd0;
                end else begin
                    score_inc[4*i +: 4] = score_q[4*i +: 4] + 4'd1;
                    carry = 1'b0;
                end
            end
        end
    end

    // A count above P-1 (left over after a level change) fires on the next tick.
    always_comb begin
        step_period = STEP_BASE - int'(level_q);
        if (step_period < STEP_MIN) step_period = STEP_MIN;
        step_due = int'(step_cnt_q) >= (step_period - 1);
    end

    always_comb begin
        state_d    = state_q;
        step_cnt_d = step_cnt_q;
        hold_d     = hold_q;
        lvl_cnt_d  = lvl_cnt_q;
        score_d    = score_q;
        level_d    = level_q;
        step       = 1'b0;
        hs_upd     = 1'b0;
        rec_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (jump_evt) state_d = S_RUN;
            end
            S_RUN: begin
                if (collide) begin
                    state_d = S_OVER;
                    hs_upd  = 1'b1;
                end else if (tick) begin
                    if (step_due) begin
                        step       = 1'b1;
                        step_cnt_d = '0;
                        if (!score_max) begin
                            score_d = score_inc;
                            if (lvl_cnt_q == LW'(LEVEL_PTS - 1)) begin
                                lvl_cnt_d = '0;
                                if (level_q != '1) level_d = level_q + 1'b1;
                            end else begin
                                lvl_cnt_d = lvl_cnt_q + 1'b1;
                            end
                        end
                    end else begin
                        step_cnt_d = step_cnt_q + 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (tick && hold_q != HW'(OVER_HOLD)) hold_d = hold_q + 1'b1;
                if (jump_evt && hold_q == HW'(OVER_HOLD)) begin
                    state_d    = S_RUN;
                    step_cnt_d = '0;
                    hold_d     = '0;
                    lvl_cnt_d  = '0;
                    score_d    = '0;
                    level_d    = '0;
                    rec_clr    = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            step_cnt_q <= '0;
            hold_q     <= '0;
            lvl_cnt_q  <= '0;
            score_q    <= '0;
            level_q    <= '0;
        end else begin
            state_q    <= state_d;
            step_cnt_q <= step_cnt_d;
            hold_q     <= hold_d;
            lvl_cnt_q  <= lvl_cnt_d;
            score_q    <= score_d;
            level_q    <= level_d;
        end
    end

`ifdef HISCORE_EN
    logic [4*DIGITS-1:0] hiscore_q;
    logic                new_record_q;

    // Packed BCD compares correctly as an unsigned number.
    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            hiscore_q    <= '0;
            new_record_q <= 1'b0;
        end else if (hs_upd && (score_q > hiscore_q)) begin
            hiscore_q    <= score_q;
            new_record_q <= 1'b1;
        end else if (rec_clr) begin
            new_record_q <= 1'b0;
        end
    end

    assign hiscore    = hiscore_q;
    assign new_record = new_record_q;
`else
    logic unused_hs;
    assign unused_hs  = hs_upd ^ rec_clr;
    assign hiscore    = '0;
    assign new_record = 1'b0;
`endif

    assign start   = (state_q != S_IDLE);
    assign running = (state_q == S_RUN);
    assign pause   = (state_q == S_OVER);
    assign score   = score_q;
    assign level   = level_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboard bench for game_sequencer: directed runs with an expected step-event queue and direct state checks.
module tb_game_sequencer;
    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       jump = 1'b1;
    logic       collide = 1'b0;
    logic       start, running, pause, step, new_record;
    logic [7:0] score, hiscore;
    logic [2:0] level;

    int n_checks = 0;
    int n_errors = 0;
    int run_tick = 0;
    logic [26:0] exp_q[$];

    game_sequencer dut (
        .clock(clock), .rst(rst), .tick(tick), .jump(jump), .collide(collide),
        .start(start), .running(running), .pause(pause), .step(step),
        .score(score), .level(level), .hiscore(hiscore), .new_record(new_record)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Each step event must match the front entry: {tick index in run, score, level}.
    always @(negedge clock) begin
        logic [26:0] e;
        if (rst && step) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_step: got step at run tick %0d expected none", run_tick);
            end else begin
                e = exp_q.pop_front();
                check("step_event", {5'b0, run_tick[15:0], score, level}, {5'b0, e});
            end
        end
    end

    function automatic logic [7:0] to_bcd(input int v);
        logic [3:0] hi, lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    // Decimal reference for a run of n steps starting from score 0, level 0.
    task automatic push_run(input int n);
        int sc, lvl, lc, t, p;
        sc = 0; lvl = 0; lc = 0; t = 0;
        for (int k = 0; k < n; k++) begin
            p = 8 - lvl;
            if (p < 2) p = 2;
            t += p;
            exp_q.push_back({t[15:0], to_bcd(sc), lvl[2:0]});
            if (sc < 99) begin
                sc++;
                lc++;
                if (lc == 10) begin
                    lc = 0;
                    if (lvl < 7) lvl++;
                end
            end
        end
    endtask

    task automatic do_tick();
        @(posedge clock); #1 tick = 1'b1; run_tick++;
        @(posedge clock); #1 tick = 1'b0;
    endtask

    task automatic tick_to(input int n);
        while (run_tick < n) do_tick();
    endtask

    task automatic press_jump();
        @(posedge clock); #1 jump = 1'b0;
        repeat (3) @(posedge clock);
        #1 jump = 1'b1;
        repeat (3) @(posedge clock);
        #1 run_tick = 0;
    endtask

    task automatic do_collide(input logic with_tick);
        @(posedge clock); #1 collide = 1'b1; tick = with_tick;
        if (with_tick) run_tick++;
        @(posedge clock); #1 collide = 1'b0; tick = 1'b0;
        @(posedge clock); #1;
    endtask

    task automatic check_hs(input string name, input logic [7:0] hs, input logic nr);
`ifdef HISCORE_EN
        check({name, "_hiscore"}, hiscore, hs);
        check({name, "_new_record"}, new_record, nr);
`else
        check({name, "_hiscore"}, hiscore, 8'h00);
        check({name, "_new_record"}, new_record, 1'b0);
        if (hs == 8'hff && nr) $display("unreachable marker");
`endif
    endtask

    task automatic check_all_zero(input string name);
        check({name, "_start"}, start, 0);
        check({name, "_running"}, running, 0);
        check({name, "_pause"}, pause, 0);
        check({name, "_step"}, step, 0);
        check({name, "_score"}, score, 0);
        check({name, "_level"}, level, 0);
        check({name, "_hiscore"}, hiscore, 0);
        check({name, "_new_record"}, new_record, 0);
    endtask

    task automatic restart_after_hold();
        repeat (16) do_tick();
        press_jump();
    endtask

    initial begin
        // Reset with ticks toggling, then ticks alone must not start a run.
        repeat (4) do_tick();
        check_all_zero("reset");
        @(posedge clock); #1 rst = 1'b1;
        repeat (10) do_tick();
        check("idle_start", start, 0);
        check("idle_running", running, 0);

        // Run 1: ends at 23.
        press_jump();
        check("run1_start", start, 1);
        check("run1_running", running, 1);
        check("run1_score0", score, 8'h00);
        push_run(23);
        tick_to(64);
        check("run1_score8", score, 8'h08);
        check("run1_level0", level, 0);
        tick_to(80);
        check("run1_score10", score, 8'h10);
        check("run1_level1", level, 1);
        tick_to(86);
        check("run1_p7_before", score, 8'h10);
        tick_to(87);
        check("run1_p7_fire", score, 8'h11);
        tick_to(168);
        check("run1_score23", score, 8'h23);
        check("run1_level2", level, 2);
        do_collide(1'b0);
        check("run1_pause", pause, 1);
        check("run1_over_running", running, 0);
        check("run1_over_start", start, 1);
        check_hs("run1", 8'h23, 1'b1);

        // Restart hold: jump after 5 ticks is ignored.
        repeat (5) do_tick();
        press_jump();
        check("hold_ignored_pause", pause, 1);
        check("hold_ignored_running", running, 0);
        repeat (11) do_tick();
        press_jump();
        check("restart_running", running, 1);
        check("restart_score", score, 8'h00);
        check("restart_level", level, 0);
        check("restart_new_record", new_record, 0);

        // Run 2: ends at 12 with collide on a step-eligible tick.
        push_run(12);
        tick_to(94);
        check("run2_score12", score, 8'h12);
        check("run2_level1", level, 1);
        tick_to(100);
        do_collide(1'b1);
        check("run2_collide_score", score, 8'h12);
        check("run2_collide_pause", pause, 1);
        check_hs("run2", 8'h23, 1'b0);

        // Run 3: level floor, level and score saturation.
        restart_after_hold();
        check("run3_running", running, 1);
        push_run(105);
        tick_to(350);
        check("run3_score70", score, 8'h70);
        check("run3_level7", level, 7);
        tick_to(408);
        check("run3_score99", score, 8'h99);
        check("run3_level_sat", level, 7);
        tick_to(420);
        check("run3_score_sat", score, 8'h99);
        tick_to(421);
        do_collide(1'b1);
        check("run3_pause", pause, 1);
        check_hs("run3", 8'h99, 1'b1);

        // Reset mid-run discards everything.
        restart_after_hold();
        push_run(2);
        tick_to(16);
        check("run4_score2", score, 8'h02);
        @(posedge clock); #1 rst = 1'b0;
        repeat (4) do_tick();
        check_all_zero("midrun_reset");
        @(posedge clock); #1 rst = 1'b1;
        repeat (6) do_tick();
        check("post_reset_idle", start, 0);

        check("exp_q_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
